wr_burst_buffer: RTL
====================

Name: wr_burst_buffer

Overview:
Downstream stage of the 32->64 data concatenator in the DMA write path. It captures the strobe-only packed-word stream (no backpressure) into a FIFO and groups the words into fixed-length bursts. For each burst it issues a request/ack handshake to the write master, then streams the beats with valid/ready and a last flag. A flush input emits a trailing partial burst at end of transfer.

Parameters:
DW, 64, data width; equals the concatenator output width.
BURST_LEN, 16, beats per full burst; 1..256.
FIFO_DEPTH, 64, FIFO entries; power of two, >= 2*BURST_LEN.
AW (localparam), log2(FIFO_DEPTH), pointer width.

Ports:
I_Clk  in  1  clock.
I_Rst  in  1  reset, asynchronous, active-high.
I_Data_De  in  1  input word strobe; one word per cycle when high.
I_Data  in  DW  input word.
I_Flush  in  1  single-cycle pulse: drain all buffered words, including a partial burst.
O_Req  out  1  burst request.
O_Req_Len  out  8  beats-1 of the requested burst; stable while O_Req=1.
I_Req_Ack  in  1  request accepted.
O_Data_Valid  out  1  beat valid.
O_Data  out  DW  beat data; FIFO head, first-word-fall-through.
O_Data_Last  out  1  final beat of the burst; qualified by O_Data_Valid.
I_Data_Ready  in  1  sink ready.
O_Fill  out  AW+1  FIFO occupancy, registered.
O_Ovf  out  1  sticky overflow flag.
O_Busy  out  1  high when state != IDLE or flush is pending.

Behaviour:
- Reset (async assert, sync release): FIFO pointers = 0; O_Fill = 0; state = IDLE; flush_pend = 0; O_Req = 0; O_Req_Len = 0; O_Data_Valid = 0; O_Data_Last = 0; O_Ovf = 0; O_Busy = 0. O_Data is don't-care. Reset mid-burst discards all FIFO contents; no partial beats after release.
- FIFO write:
  - Write when I_Data_De=1 and (O_Fill < FIFO_DEPTH, or a read occurs in the same cycle).
  - Otherwise, I_Data_De=1 drops the word and sets O_Ovf=1 until reset.
- O_Fill update: +1 on write only; -1 on read only; unchanged on both or neither. A word written at cycle N is counted in O_Fill at N+1.
- Read: occurs on O_Data_Valid & I_Data_Ready. Pointers wrap modulo FIFO_DEPTH.
- flush_pend: set by I_Flush (set wins over a same-cycle clear); cleared as described under IDLE.
- FSM states IDLE, REQ, DATA; all decisions use registered O_Fill.
- IDLE:
  - If O_Fill >= BURST_LEN: len = BURST_LEN, go to REQ. flush_pend stays set.
  - Else if flush_pend and O_Fill > 0: len = O_Fill (snapshot), clear flush_pend, go to REQ.
  - Else if flush_pend and O_Fill = 0: clear flush_pend, stay in IDLE.
- REQ:
  - O_Req=1 and O_Req_Len=len-1, both registered.
  - On I_Req_Ack=1: drop O_Req next cycle, clear beat counter, go to DATA.
  - O_Req may be held indefinitely.
- DATA:
  - O_Data_Valid=1.
  - O_Data_Last = (beat == len-1).
  - Each handshake increments beat.
  - Handshake with O_Data_Last=1 → IDLE; O_Data_Valid=0 the next cycle.
  - Valid never drops mid-burst. Data for a burst is guaranteed present because len <= O_Fill at snapshot.
- Latency: the BURST_LEN-th write at cycle N gives O_Req=1 at N+2 at the earliest. Back-to-back bursts: IDLE costs one cycle after the last beat.
- Simultaneous events:
  - Writes continue during REQ and DATA.
  - Write+read at full is accepted without overflow.
  - I_Flush during DATA is remembered and acted on at the next IDLE.
  - Words arriving after a partial-burst snapshot stay in the FIFO for a later burst or flush.
- BURST_LEN=1: every burst has O_Data_Last=1 on its only beat.

Test Plan:
- 32 writes, values 0..31, I_Req_Ack one cycle after O_Req, ready=1 → two bursts with O_Req_Len=15; O_Data 0..15 with Last on 15, then 16..31 with Last on 31; O_Fill returns to 0; O_Ovf=0.
- 5 writes (0xA0..0xA4), then I_Flush → one burst with O_Req_Len=4, beats A0..A4, Last on A4; O_Busy drops after it; a second I_Flush with the FIFO empty raises no O_Req.
- 70 consecutive writes, I_Req_Ack held low → O_Fill saturates at 64 and O_Ovf=1; after acking and draining, the words out are the first 64 in order.
- Ready toggled 1/0 every cycle during a 16-beat burst → exactly 16 handshakes; Valid stays high throughout; Last only on beat 15; data in order.
- I_Rst asserted at beat 7 of a burst → all outputs go to reset values immediately; after release O_Fill=0 and no O_Req until 16 new writes arrive.
- 20 writes, then I_Flush, with ack immediate → a burst of len 16, then a burst of len 4 (O_Req_Len=3) with values 16..19.

Source files
------------

// File: rtl/wr_burst_buffer.sv
// Write-path burst former: buffers the packed-word stream in a FIFO and emits
// fixed-length (or flushed partial) bursts via a req/ack then valid/ready beat stream.
module wr_burst_buffer #(
    parameter int DW         = 64,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          I_Clk,
    input  logic          I_Rst,
    input  logic          I_Data_De,
    input  logic [DW-1:0] I_Data,
    input  logic          I_Flush,
    output logic          O_Req,
    output logic [7:0]    O_Req_Len,
    input  logic          I_Req_Ack,
    output logic          O_Data_Valid,
    output logic [DW-1:0] O_Data,
    output logic          O_Data_Last,
    input  logic          I_Data_Ready,
    output logic [AW:0]   O_Fill,
    output logic          O_Ovf,
    output logic          O_Busy
);

    localparam int AWP = AW + 1;
    localparam logic [AW:0] DEPTH_F = AWP'(FIFO_DEPTH);
    localparam logic [AW:0] BURST_F = AWP'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic          flush_q, flush_d;
    logic [8:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic          req_q, req_d;
    logic [7:0]    req_len_q, req_len_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          wr_en, rd_en;

    logic [DW-1:0] mem [FIFO_DEPTH];

    // A read in the same cycle frees a slot, so a write at full is still accepted.
    always_comb begin
        rd_en    = valid_q & I_Data_Ready;
        wr_en    = I_Data_De & ((fill_q < DEPTH_F) | rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        ovf_d    = ovf_q | (I_Data_De & ~wr_en);
        case ({wr_en, rd_en})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        len_d     = len_q;
        beat_d    = beat_q;
        req_d     = req_q;
        req_len_d = req_len_q;
        valid_d   = valid_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (fill_q >= BURST_F) begin
                    len_d     = 9'(BURST_LEN);
                    req_len_d = 8'(BURST_LEN - 1);
                    req_d     = 1'b1;
                    state_d   = REQ;
                end else if (flush_q) begin
                    flush_d = 1'b0;
                    if (fill_q != '0) begin
                        len_d     = 9'(fill_q);
                        req_len_d = 8'(fill_q - 1'b1);
                        req_d     = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (I_Req_Ack) begin
                    req_d   = 1'b0;
                    beat_d  = '0;
                    valid_d = 1'b1;
                    last_d  = (len_q == 9'd1);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rd_en) begin
                    beat_d = beat_q + 1'b1;
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // next beat is the final one when beat+1 == len-1
                        last_d = ({1'b0, beat_q} + 9'd2 == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (I_Flush) flush_d = 1'b1;
    end

    always_ff @(posedge I_Clk or posedge I_Rst) begin
        if (I_Rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
            flush_q   <= 1'b0;
            len_q     <= '0;
            beat_q    <= '0;
            req_q     <= 1'b0;
            req_len_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            flush_q   <= flush_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            req_q     <= req_d;
            req_len_q <= req_len_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge I_Clk) begin
        if (wr_en) mem[wr_ptr_q] <= I_Data;
    end

    assign O_Req        = req_q;
    assign O_Req_Len    = req_len_q;
    assign O_Data_Valid = valid_q;
    assign O_Data       = mem[rd_ptr_q];
    assign O_Data_Last  = last_q;
    assign O_Fill       = fill_q;
    assign O_Ovf        = ovf_q;
    assign O_Busy       = (state_q != IDLE) | flush_q;

endmodule
